// File: rtl/tl_cntr_timed.sv
// Two-road traffic-light controller with protected left-turn phases and a per-state cycle timer.
// Define TL_MAX_GREEN_EN to enable the max-green timeout on green and left states.
module tl_cntr_timed #(
    parameter int YELLOW_CYC    = 2,
    parameter int MIN_GREEN_CYC = 4,
    parameter int MAX_GREEN_CYC = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] phase
);

    localparam int TW = $clog2(MAX_GREEN_CYC + 1);
    localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN_CYC - 1);
    localparam logic [TW-1:0] YEL_T = TW'(YELLOW_CYC - 1);
`ifdef TL_MAX_GREEN_EN
    localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN_CYC - 1);
`endif

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;
    localparam logic [1:0] L_LEFT   = 2'b11;

    typedef enum logic [2:0] {
        S0_A_GREEN, S1_A_YELLOW, S2_A_LEFT, S3_A_LEFT_YEL,
        S4_B_GREEN, S5_B_YELLOW, S6_B_LEFT, S7_B_LEFT_YEL
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] t;
    logic          gov;
    logic          max_hit;
    logic          hold_exit;
    logic          yel_exit;

    // NOTE: state and timer use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S0_A_GREEN;
            t     <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) t <= '0;
            else if (t != '1)        t <= t + 1'b1;
        end
    end

`ifdef TL_MAX_GREEN_EN
    assign max_hit = (t >= MAX_T);
`else
    assign max_hit = 1'b0;
`endif

    assign hold_exit = (t >= MIN_T) && (!gov || max_hit);
    assign yel_exit  = (t == YEL_T);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        gov        = 1'b0;
        case (state)
            S0_A_GREEN: begin
                gov = Ta;
                if (hold_exit) state_next = S1_A_YELLOW;
            end
            S1_A_YELLOW:   if (yel_exit) state_next = Tal ? S2_A_LEFT : S4_B_GREEN;
            S2_A_LEFT: begin
                gov = Tal;
                if (hold_exit) state_next = S3_A_LEFT_YEL;
            end
            S3_A_LEFT_YEL: if (yel_exit) state_next = S4_B_GREEN;
            S4_B_GREEN: begin
                gov = Tb;
                if (hold_exit) state_next = S5_B_YELLOW;
            end
            S5_B_YELLOW:   if (yel_exit) state_next = Tbl ? S6_B_LEFT : S0_A_GREEN;
            S6_B_LEFT: begin
                gov = Tbl;
                if (hold_exit) state_next = S7_B_LEFT_YEL;
            end
            S7_B_LEFT_YEL: if (yel_exit) state_next = S0_A_GREEN;
            default:       state_next = S0_A_GREEN;
        endcase
    end

    // Lamps are decoded from the state register only; sensors never reach them combinationally.
    always_comb begin
        La = L_RED;
        Lb = L_RED;
        case (state)
            S0_A_GREEN:    La = L_GREEN;
            S1_A_YELLOW:   La = L_YELLOW;
            S2_A_LEFT:     La = L_LEFT;
            S3_A_LEFT_YEL: La = L_YELLOW;
            S4_B_GREEN:    Lb = L_GREEN;
            S5_B_YELLOW:   Lb = L_YELLOW;
            S6_B_LEFT:     Lb = L_LEFT;
            S7_B_LEFT_YEL: Lb = L_YELLOW;
            default: begin
                La = L_RED;
                Lb = L_RED;
            end
        endcase
    end

    assign phase = state;

endmodule
